// File: rtl/sa_ctrl_pkg.sv
// Shared types and sequencing constants for the systolic-array feed controller.
package sa_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int FEED_LEN(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int DRAIN_LEN(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// One skewed feed lane: presents element (phase - LANE) of its vector while that
// index lies inside the matrix, otherwise zero.
module sa_skew_lane
  import sa_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int N         = 16,
  localparam int PW       = $clog2(2 * N)
) (
  input  logic                   en,
  input  logic [PW-1:0]          phase,
  input  logic [BIT_WIDTH*N-1:0] elems,
  input  logic [PW-1:0]          lane,
  output logic [BIT_WIDTH-1:0]   elem
);

  localparam int OW = PW + 1;

  logic [OW-1:0] offs;

  // One extra bit so phase < lane wraps far above N and reads as out of range.
  always_comb begin
    elem = '0;
    offs = {1'b0, phase} - {1'b0, lane};
    if (en && (offs < OW'(N))) begin
      for (int k = 0; k < N; k++) begin
        if (offs == OW'(k)) begin
          elem = elems[k*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/sa_feed_controller.sv
// Sequences one NxN multiply on the systolic array: buffers A/B, then clear, skewed feed, drain, done.
// Optional performance counters (job_cnt, busy_cyc) are built when SA_CTRL_PERF_EN is defined.
module sa_feed_controller
  import sa_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int N         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [BIT_WIDTH*N-1:0] wr_data,
  output logic                   wr_err,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   sa_clr,
  output logic                   sa_en,
  output logic [BIT_WIDTH*N-1:0] sa_a,
  output logic [BIT_WIDTH*N-1:0] sa_b
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]            job_cnt,
  output logic [31:0]            busy_cyc
`endif
);

  localparam int PW = $clog2(2 * N);
  localparam logic [PW-1:0] FEED_LAST  = PW'(FEED_LEN(N) - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_LEN(N) - 1);

  state_t                 state_reg, state_next;
  logic [PW-1:0]          phase_reg, phase_next;
  logic                   wr_err_reg;
  logic                   wr_ok;
  logic                   feed_en;
  logic [BIT_WIDTH*N-1:0] a_mem [N];
  logic [BIT_WIDTH*N-1:0] b_mem [N];

  assign wr_ok  = wr_en && ((state_reg == IDLE) || (state_reg == DONE));
  assign wr_err = wr_err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      phase_reg  <= '0;
      wr_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      wr_err_reg <= wr_en && !wr_ok;
    end
  end

  // Row buffers are flops: every feed cycle reads a full diagonal in parallel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++) begin
        a_mem[r] <= '0;
        b_mem[r] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel == SEL_A) a_mem[wr_row] <= wr_data;
      else                 b_mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    busy       = 1'b0;
    done       = 1'b0;
    sa_clr     = 1'b0;
    sa_en      = 1'b0;
    feed_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        busy       = 1'b1;
        sa_clr     = 1'b1;
        state_next = FEED;
        phase_next = '0;
      end
      FEED: begin
        busy    = 1'b1;
        sa_en   = 1'b1;
        feed_en = 1'b1;
        if (phase_reg == FEED_LAST) begin
          state_next = DRAIN;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      DRAIN: begin
        busy  = 1'b1;
        sa_en = 1'b1;
        if (phase_reg == DRAIN_LAST) begin
          state_next = DONE;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi, gk;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [BIT_WIDTH*N-1:0] b_col;

      // Column gi of B gathered so B lanes share the row-lane selector.
      for (gk = 0; gk < N; gk++) begin : g_col
        assign b_col[gk*BIT_WIDTH +: BIT_WIDTH] = b_mem[gk][gi*BIT_WIDTH +: BIT_WIDTH];
      end

      sa_skew_lane #(.BIT_WIDTH(BIT_WIDTH), .N(N)) u_lane_a (
        .en    (feed_en),
        .phase (phase_reg),
        .elems (a_mem[gi]),
        .lane  (PW'(gi)),
        .elem  (sa_a[gi*BIT_WIDTH +: BIT_WIDTH])
      );

      sa_skew_lane #(.BIT_WIDTH(BIT_WIDTH), .N(N)) u_lane_b (
        .en    (feed_en),
        .phase (phase_reg),
        .elems (b_col),
        .lane  (PW'(gi)),
        .elem  (sa_b[gi*BIT_WIDTH +: BIT_WIDTH])
      );
    end
  endgenerate

`ifdef SA_CTRL_PERF_EN
  logic [31:0] job_cnt_reg;
  logic [31:0] busy_cyc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      job_cnt_reg  <= '0;
      busy_cyc_reg <= '0;
    end else begin
      if (done && (job_cnt_reg != '1))  job_cnt_reg  <= job_cnt_reg + 32'd1;
      if (busy && (busy_cyc_reg != '1)) busy_cyc_reg <= busy_cyc_reg + 32'd1;
    end
  end

  assign job_cnt  = job_cnt_reg;
  assign busy_cyc = busy_cyc_reg;
`else
  // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_sa_feed_controller.sv
// Self-checking bench: drives the controller into a behavioural output-stationary array
// and scoreboards the accumulated C matrix against a software multiply.
module tb_sa_feed_controller;

  localparam int BW = 8;
  localparam int N  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [1:0]  wr_row = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        wr_err, busy, done, sa_clr, sa_en;
  logic [31:0] sa_a, sa_b;
`ifdef SA_CTRL_PERF_EN
  logic [31:0] job_cnt, busy_cyc;
`endif

  int total = 0;
  int bad   = 0;
  int jobs  = 0;

  logic [7:0]   ma [4][4];
  logic [7:0]   mb [4][4];
  logic [127:0] exp_q [$];
  logic [127:0] mon_exp;

  always #5 clk = ~clk;

  sa_feed_controller #(.BIT_WIDTH(BW), .N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .wr_err  (wr_err),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .sa_clr  (sa_clr),
    .sa_en   (sa_en),
    .sa_a    (sa_a),
    .sa_b    (sa_b)
`ifdef SA_CTRL_PERF_EN
    ,
    .job_cnt (job_cnt),
    .busy_cyc(busy_cyc)
`endif
  );

  // Behavioural 4x4 output-stationary array: A flows right, B flows down, mod 2^8 accumulate.
  logic [7:0]   pa [4][4];
  logic [7:0]   pb [4][4];
  logic [7:0]   acc [4][4];
  logic [7:0]   a_in [4][4];
  logic [7:0]   b_in [4][4];
  logic [127:0] c_flat;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_in[i][0] = sa_a[i*8 +: 8];
      b_in[0][i] = sa_b[i*8 +: 8];
      for (int j = 1; j < 4; j++) begin
        a_in[i][j] = pa[i][j-1];
        b_in[j][i] = pb[j-1][i];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (sa_clr) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else if (sa_en) begin
          acc[i][j] <= acc[i][j] + a_in[i][j] * b_in[i][j];
          pa[i][j]  <= a_in[i][j];
          pb[i][j]  <= b_in[i][j];
        end
      end
    end
  end

  always_comb begin
    c_flat = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        c_flat[(r*4+c)*8 +: 8] = acc[r][c];
  end

  // Scoreboard consumer: every done pulse retires one expected C.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      total++;
      jobs++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL done_without_job: got done=1 required no pulse (job %0d)", jobs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (c_flat !== mon_exp) begin
          bad++;
          $display("FAIL c_matrix job %0d: got %h required %h", jobs, c_flat, mon_exp);
        end else begin
          $display("job %0d: C=%h matches", jobs, c_flat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] a_row(input int r);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = ma[r][k];
    return v;
  endfunction

  function automatic logic [31:0] b_row(input int r);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = mb[r][k];
    return v;
  endfunction

  task automatic write_row(input logic sel, input int row, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = 2'(row);
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic load_buffers();
    for (int r = 0; r < 4; r++) begin
      write_row(1'b0, r, a_row(r));
      write_row(1'b1, r, b_row(r));
    end
  endtask

  task automatic push_expected();
    logic [127:0] e;
    logic [7:0]   s;
    e = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = '0;
        for (int k = 0; k < 4; k++) s = s + ma[r][k] * mb[k][c];
        e[(r*4+c)*8 +: 8] = s;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic launch();
    start = 1'b1;
    push_expected();
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        n = k;
        return;
      end
      step();
    end
  endtask

  task automatic set_case1();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = (r == c) ? 8'd1 : 8'd0;
        mb[r][c] = 8'(4 * r + c);
      end
  endtask

  task automatic set_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'($urandom_range(0, 255));
        mb[r][c] = 8'($urandom_range(0, 255));
      end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    total++;
    if ({wr_err, busy, done, sa_clr, sa_en} !== 5'b0 || sa_a !== '0 || sa_b !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ctl=%b a=%h b=%h required all zero",
               {wr_err, busy, done, sa_clr, sa_en}, sa_a, sa_b);
    end
`ifdef SA_CTRL_PERF_EN
    total++;
    if (job_cnt !== 32'd0 || busy_cyc !== 32'd0) begin
      bad++;
      $display("FAIL reset_perf: got job_cnt=%0d busy_cyc=%0d required 0 0", job_cnt, busy_cyc);
    end
`endif
    reset = 1'b1;
    step(); step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_identity();
    logic [66:0] got, req;
    logic [31:0] ea, eb;
    int done_at, t, d;
    set_case1();
    load_buffers();
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("FAIL idle_write_err: got wr_err=%b required 0", wr_err);
    end
    launch();
    done_at = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
      if (n <= 11) begin
        ea = '0;
        eb = '0;
        if (n >= 2 && n <= 8) begin
          t = n - 2;
          for (int i = 0; i < 4; i++) begin
            d = t - i;
            if (d >= 0 && d < 4) begin
              ea[i*8 +: 8] = ma[i][d];
              eb[i*8 +: 8] = mb[d][i];
            end
          end
        end
        got = {busy, sa_clr, sa_en, sa_a, sa_b};
        req = {1'b1, (n == 1), (n >= 2), ea, eb};
        total++;
        if (got !== req) begin
          bad++;
          $display("FAIL feed_cycle %0d: got %h required %h", n, got, req);
        end
      end
      step();
    end
    total++;
    if (done_at != 12) begin
      bad++;
      $display("FAIL done_latency: got %0d required 12", done_at);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: got done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_all_twos();
    int bc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'd2;
        mb[r][c] = 8'd2;
      end
    load_buffers();
    launch();
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy !== 1'b1) break;
      bc++;
      step();
    end
    total++;
    if (bc != 11) begin
      bad++;
      $display("FAIL busy_length: got %0d required 11", bc);
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_after_busy: got %b required 1", done);
    end
    step();
  endtask

  task automatic test_wr_during_feed();
    int errs;
    set_random();
    load_buffers();
    launch();
    step(); step();
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_row  = 2'd1;
    wr_data = '1;
    errs = (wr_err === 1'b1) ? 1 : 0;
    step();
    wr_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (wr_err === 1'b1) errs++;
      if (done === 1'b1) break;
      step();
    end
    total++;
    if (errs != 1) begin
      bad++;
      $display("FAIL wr_err_pulses: got %0d required 1", errs);
    end
    step();
  endtask

  task automatic test_start_in_drain();
    int pulses;
    set_random();
    load_buffers();
    launch();
    repeat (8) step();
    start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) pulses++;
      step();
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL drain_start_done_count: got %0d required 1", pulses);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drain_start_restart: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_feed();
    logic [127:0] dropped;
    int n;
    set_case1();
    load_buffers();
    launch();
    repeat (4) step();
    reset = 1'b0;
    dropped = exp_q.pop_back();
    step();
    total++;
    if ({wr_err, busy, done, sa_clr, sa_en} !== 5'b0 || sa_a !== '0 || sa_b !== '0) begin
      bad++;
      $display("FAIL mid_feed_reset: got ctl=%b a=%h b=%h required all zero (dropped C %h)",
               {wr_err, busy, done, sa_clr, sa_en}, sa_a, sa_b, dropped);
    end
    reset = 1'b1;
    step();
    // Buffers were cleared by reset, so an unwritten job must yield C = 0.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'd0;
        mb[r][c] = 8'd0;
      end
    launch();
    wait_done(n);
    total++;
    if (n < 0) begin
      bad++;
      $display("FAIL cleared_job_timeout: got no done required done within 40 cycles");
    end
    step();
    set_case1();
    load_buffers();
    launch();
    wait_done(n);
    total++;
    if (n < 0) begin
      bad++;
      $display("FAIL rerun_timeout: got no done required done within 40 cycles");
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = (r == c) ? 8'd1 : 8'd0;
        mb[r][c] = 8'($urandom_range(0, 15));
      end
    load_buffers();
    launch();
    wait_done(n);
    total++;
    if (n < 0) begin
      bad++;
      $display("FAIL job1_timeout: got no done required done within 40 cycles");
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ma[r][c] = (r == c) ? 8'd2 : 8'd0;
    // Row 0 lands during DONE, rows 1-2 in IDLE, row 3 together with start.
    write_row(1'b0, 0, a_row(0));
    write_row(1'b0, 1, a_row(1));
    write_row(1'b0, 2, a_row(2));
    start = 1'b1;
    push_expected();
    write_row(1'b0, 3, a_row(3));
    start = 1'b0;
    wait_done(n);
    total++;
    if (n < 0) begin
      bad++;
      $display("FAIL job2_timeout: got no done required done within 40 cycles");
    end
    step();
`ifdef SA_CTRL_PERF_EN
    total++;
    if (job_cnt !== 32'd2 || busy_cyc !== 32'd22) begin
      bad++;
      $display("FAIL perf_counters: got job_cnt=%0d busy_cyc=%0d required 2 22", job_cnt, busy_cyc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_twos();
    test_wr_during_feed();
    test_start_in_drain();
    test_reset_mid_feed();
    test_back_to_back();
    repeat (3) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_jobs: got %0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
